// File: rtl/sgpr_pkg.sv
// Shared widths, read-only SGPR address map and queue entry type for the
// scalar register file write-back path.
package sgpr_pkg;

    localparam int SGPR_ADDR_W = 8;
    localparam int SGPR_DATA_W = 64;

    localparam logic [SGPR_ADDR_W-1:0] RO_M0         = 8'h7D;
    localparam logic [SGPR_ADDR_W-1:0] RO_CONST_LO   = 8'h80;
    localparam logic [SGPR_ADDR_W-1:0] RO_CONST_HI   = 8'hE8;
    localparam logic [SGPR_ADDR_W-1:0] RO_SPECIAL_LO = 8'hF0;
    localparam logic [SGPR_ADDR_W-1:0] RO_SPECIAL_HI = 8'hF8;

    typedef struct packed {
        logic [SGPR_ADDR_W-1:0] addr;
        logic [SGPR_DATA_W-1:0] data;
        logic                   is64;
    } sgpr_entry_t;

    function automatic logic is_read_only(input logic [SGPR_ADDR_W-1:0] addr);
        return (addr == RO_M0)
            || (addr >= RO_CONST_LO   && addr <= RO_CONST_HI)
            || (addr >= RO_SPECIAL_LO && addr <= RO_SPECIAL_HI);
    endfunction

    // A 64-bit write covers {addr+1, addr}; a pair wrapping past the top is never legal.
    function automatic logic is_dropped(input logic [SGPR_ADDR_W-1:0] addr, input logic is64);
        logic [SGPR_ADDR_W-1:0] hi;
        hi = addr + SGPR_ADDR_W'(1);
        return is_read_only(addr) || (is64 && ((addr == '1) || is_read_only(hi)));
    endfunction

endpackage

// File: rtl/sgpr_writeback_queue_if.sv
// Signal bundle between the SALU/operand-fetch side and sgpr_writeback_queue.
// drop_cnt is present only when SGPR_WB_DROP_CNT_EN is defined.
interface sgpr_writeback_queue_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 64,
    parameter int CNT_W  = 3
);
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_addr;
    logic [DATA_W-1:0] in_data;
    logic              in_is64;
    logic              rf_hold;
    logic              rf_en_w;
    logic              rf_en_64;
    logic [ADDR_W-1:0] rf_w0;
    logic [DATA_W-1:0] rf_wv;
    logic [ADDR_W-1:0] q0_addr;
    logic [ADDR_W-1:0] q1_addr;
    logic              q0_busy;
    logic              q1_busy;
    logic              drop_err;
    logic [CNT_W-1:0]  count;
`ifdef SGPR_WB_DROP_CNT_EN
    logic [15:0]       drop_cnt;

    modport master (
        output in_valid, in_addr, in_data, in_is64, rf_hold, q0_addr, q1_addr,
        input  in_ready, rf_en_w, rf_en_64, rf_w0, rf_wv, q0_busy, q1_busy, drop_err, count,
               drop_cnt
    );
    modport slave (
        input  in_valid, in_addr, in_data, in_is64, rf_hold, q0_addr, q1_addr,
        output in_ready, rf_en_w, rf_en_64, rf_w0, rf_wv, q0_busy, q1_busy, drop_err, count,
               drop_cnt
    );
`else
    modport master (
        output in_valid, in_addr, in_data, in_is64, rf_hold, q0_addr, q1_addr,
        input  in_ready, rf_en_w, rf_en_64, rf_w0, rf_wv, q0_busy, q1_busy, drop_err, count
    );
    modport slave (
        input  in_valid, in_addr, in_data, in_is64, rf_hold, q0_addr, q1_addr,
        output in_ready, rf_en_w, rf_en_64, rf_w0, rf_wv, q0_busy, q1_busy, drop_err, count
    );
`endif
endinterface

// File: rtl/sgpr_wb_fifo.sv
// Synchronous FIFO of pending SGPR writes; exposes every slot's valid/addr/is64
// so the owner can run the RAW hazard compare against all queued entries.
module sgpr_wb_fifo
    import sgpr_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  sgpr_entry_t            push_entry_i,
    input  logic                   pop_i,
    output sgpr_entry_t            head_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [CNT_W-1:0]       count_o,
    output logic [DEPTH-1:0]       valid_o,
    output logic [DEPTH-1:0]       is64_o,
    output logic [SGPR_ADDR_W-1:0] addr_o [DEPTH]
);
    sgpr_entry_t      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // NOTE: storage has no reset; occupancy alone decides which slots are meaningful.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= push_entry_i;
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            logic [PTR_W-1:0] offset;
            offset     = PTR_W'(i) - rd_ptr_q;
            valid_o[i] = CNT_W'(offset) < count_q;
            addr_o[i]  = mem[i].addr;
            is64_o[i]  = mem[i].is64;
        end
    end
endmodule

// File: rtl/sgpr_writeback_queue.sv
// SGPR write-back queue: filters read-only targets, buffers SALU results and
// drains one RF write per cycle. Optional drop counter: SGPR_WB_DROP_CNT_EN.
module sgpr_writeback_queue
    import sgpr_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = SGPR_ADDR_W,
    parameter int DATA_W = SGPR_DATA_W
) (
    input logic              clock,
    input logic              reset_n,
    sgpr_writeback_queue_if.slave bus
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    logic              accept, drop, push, pop, full, empty;
    sgpr_entry_t       push_entry, head;
    logic [CNT_W-1:0]  count;
    logic [DEPTH-1:0]  ent_valid, ent_is64;
    logic [ADDR_W-1:0] ent_addr [DEPTH];

    logic              rf_en_w_q, rf_en_w_d, rf_en_64_q, rf_en_64_d, drop_err_q, drop_err_d;
    logic [ADDR_W-1:0] rf_w0_q, rf_w0_d;
    logic [DATA_W-1:0] rf_wv_q, rf_wv_d;
    logic              q0_hit, q1_hit;

    // Dropped writes are still handshaken; they simply never enter the FIFO.
    assign accept = bus.in_valid && !full;
    assign drop   = is_dropped(bus.in_addr, bus.in_is64);
    assign push   = accept && !drop;
    assign pop    = !empty && !bus.rf_hold;

    always_comb begin
        push_entry.addr = bus.in_addr;
        push_entry.is64 = bus.in_is64;
        push_entry.data = bus.in_is64 ? bus.in_data
                                      : {{(DATA_W-32){1'b0}}, bus.in_data[31:0]};
    end

    sgpr_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk          (clock),
        .rst_n        (reset_n),
        .push_i       (push),
        .push_entry_i (push_entry),
        .pop_i        (pop),
        .head_o       (head),
        .full_o       (full),
        .empty_o      (empty),
        .count_o      (count),
        .valid_o      (ent_valid),
        .is64_o       (ent_is64),
        .addr_o       (ent_addr)
    );

    always_comb begin
        rf_en_w_d  = pop;
        rf_en_64_d = pop && head.is64;
        rf_w0_d    = pop ? head.addr : rf_w0_q;
        rf_wv_d    = pop ? head.data : rf_wv_q;
        drop_err_d = accept && drop;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rf_en_w_q  <= 1'b0;
            rf_en_64_q <= 1'b0;
            rf_w0_q    <= '0;
            rf_wv_q    <= '0;
            drop_err_q <= 1'b0;
        end else begin
            rf_en_w_q  <= rf_en_w_d;
            rf_en_64_q <= rf_en_64_d;
            rf_w0_q    <= rf_w0_d;
            rf_wv_q    <= rf_wv_d;
            drop_err_q <= drop_err_d;
        end
    end

    // RAW lookup covers every queued entry plus the write currently on the RF port.
    always_comb begin
        q0_hit = rf_en_w_q && ((rf_w0_q == bus.q0_addr) ||
                               (rf_en_64_q && ((rf_w0_q + ADDR_ONE) == bus.q0_addr)));
        q1_hit = rf_en_w_q && ((rf_w0_q == bus.q1_addr) ||
                               (rf_en_64_q && ((rf_w0_q + ADDR_ONE) == bus.q1_addr)));
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid[i]) begin
                if ((ent_addr[i] == bus.q0_addr) ||
                    (ent_is64[i] && ((ent_addr[i] + ADDR_ONE) == bus.q0_addr))) q0_hit = 1'b1;
                if ((ent_addr[i] == bus.q1_addr) ||
                    (ent_is64[i] && ((ent_addr[i] + ADDR_ONE) == bus.q1_addr))) q1_hit = 1'b1;
            end
        end
    end

    assign bus.in_ready = !full;
    assign bus.rf_en_w  = rf_en_w_q;
    assign bus.rf_en_64 = rf_en_64_q;
    assign bus.rf_w0    = rf_w0_q;
    assign bus.rf_wv    = rf_wv_q;
    assign bus.q0_busy  = q0_hit;
    assign bus.q1_busy  = q1_hit;
    assign bus.drop_err = drop_err_q;
    assign bus.count    = count;

`ifdef SGPR_WB_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (accept && drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) drop_cnt_q <= '0;
        else          drop_cnt_q <= drop_cnt_d;
    end

    assign bus.drop_cnt = drop_cnt_q;
`endif
endmodule

// File: tb/tb_sgpr_writeback_queue.sv
// Scoreboard bench for sgpr_writeback_queue: stimulus pushes expected RF writes,
// a negedge monitor pops and compares them along with status and hazard outputs.
`timescale 1ns/1ps
module tb_sgpr_writeback_queue;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 64;
    localparam int CNT_W  = 3;

    typedef struct {
        int          addr;
        logic [63:0] data;
        bit          is64;
    } wr_t;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    sgpr_writeback_queue_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    sgpr_writeback_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    bit          ro_tab [256];
    wr_t         sb [$];
    wr_t         cur;
    bit          cur_v;
    bit          exp_drop;
    int          drop_model;
    int          prev_size;
    bit          prev_hold;
    int          last_addr;
    logic [63:0] last_data;
    bit          mon_en = 0;
    int          drv_qa, drv_qb;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s: bound expired at %0t", name, $time);
    endtask

    function automatic bit ref_drop(input int a, input bit is64);
        if (ro_tab[a]) return 1;
        if (!is64) return 0;
        if (a == 255) return 1;
        return ro_tab[a + 1];
    endfunction

    function automatic bit covers(input wr_t e, input int a);
        return (a == e.addr) || (e.is64 && (a == ((e.addr + 1) % 256)));
    endfunction

    function automatic bit model_busy(input int a);
        bit r;
        r = cur_v && covers(cur, a);
        foreach (sb[i]) if (covers(sb[i], a)) r = 1;
        return r;
    endfunction

    task automatic model_clear();
        sb.delete();
        cur_v      = 0;
        exp_drop   = 0;
        drop_model = 0;
        prev_size  = 0;
        prev_hold  = bus.rf_hold;
        last_addr  = 0;
        last_data  = '0;
    endtask

    // Called at posedge+1; the transfer decided here happens at the next edge.
    task automatic step(input bit v, input int a, input logic [63:0] d, input bit is64,
                        input bit hold, output bit fired);
        bus.in_valid = v;
        bus.in_addr  = a[7:0];
        bus.in_data  = d;
        bus.in_is64  = is64;
        bus.rf_hold  = hold;
        bus.q0_addr  = drv_qa[7:0];
        bus.q1_addr  = drv_qb[7:0];
        fired = v && (bus.in_ready === 1'b1);
        @(posedge clock);
        #1;
        exp_drop = 0;
        if (fired) begin
            if (ref_drop(a, is64)) begin
                exp_drop = 1;
                drop_model++;
            end else begin
                sb.push_back('{addr: a, data: (is64 ? d : {32'h0, d[31:0]}), is64: is64});
            end
        end
    endtask

    task automatic send(input int a, input logic [63:0] d, input bit is64, input bit hold);
        bit f;
        for (int t = 0; t < 20; t++) begin
            step(1, a, d, is64, hold, f);
            if (f) return;
        end
        fail_now("send_accept");
    endtask

    task automatic idle(input int n, input bit hold);
        bit f;
        for (int i = 0; i < n; i++) step(0, 0, '0, 0, hold, f);
    endtask

    // Monitor: compares every cycle's RF port, status and hazard outputs with the model.
    initial begin
        wr_t e;
        bit  exp_en;
        forever begin
            @(negedge clock);
            if (mon_en) begin
                exp_en = (prev_size > 0) && !prev_hold;
                check("rf_en_w", bus.rf_en_w, exp_en);
                if (bus.rf_en_w === 1'b1) begin
                    if (sb.size() == 0) begin
                        fail_now("rf_write_unexpected");
                        cur_v = 0;
                    end else begin
                        e = sb.pop_front();
                        check("rf_w0",    bus.rf_w0,    64'(e.addr));
                        check("rf_wv",    bus.rf_wv,    e.data);
                        check("rf_en_64", bus.rf_en_64, e.is64);
                        cur = e;  cur_v = 1;
                        last_addr = e.addr;  last_data = e.data;
                    end
                end else begin
                    cur_v = 0;
                    check("rf_en_64_idle", bus.rf_en_64, 0);
                    check("rf_w0_hold",    bus.rf_w0,    64'(last_addr));
                    check("rf_wv_hold",    bus.rf_wv,    last_data);
                end
                check("count",    bus.count,    64'(sb.size()));
                check("in_ready", bus.in_ready, sb.size() != DEPTH);
                check("drop_err", bus.drop_err, exp_drop);
                check("q0_busy",  bus.q0_busy,  model_busy(int'(bus.q0_addr)));
                check("q1_busy",  bus.q1_busy,  model_busy(int'(bus.q1_addr)));
`ifdef SGPR_WB_DROP_CNT_EN
                check("drop_cnt", bus.drop_cnt, (drop_model > 65535) ? 64'd65535 : 64'(drop_model));
`endif
                prev_size = sb.size();
                prev_hold = bus.rf_hold;
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit f;
        int drops [16];
        bit d64 [16];
        for (int a = 0; a < 256; a++)
            ro_tab[a] = (a == 125) || (a >= 128 && a <= 232) || (a >= 240 && a <= 248);

        drv_qa = 0;  drv_qb = 0;
        bus.in_valid = 0;  bus.in_addr = '0;  bus.in_data = '0;  bus.in_is64 = 0;
        bus.rf_hold = 0;   bus.q0_addr = '0;  bus.q1_addr = '0;
        repeat (3) @(posedge clock);
        #1;
        reset_n = 1;
        check("rst_count",    bus.count,    0);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_rf_en_w",  bus.rf_en_w,  0);
        check("rst_rf_en_64", bus.rf_en_64, 0);
        check("rst_rf_w0",    bus.rf_w0,    0);
        check("rst_rf_wv",    bus.rf_wv,    0);
        check("rst_drop_err", bus.drop_err, 0);
        model_clear();
        mon_en = 1;

        // Single 32-bit write: upper data bits must be zeroed, two-cycle latency.
        send(8'h05, 64'hDEAD_BEEF_1234_5678, 0, 0);
        check("lat_not_yet", bus.rf_en_w, 0);
        idle(1, 0);
        check("lat_en_w", bus.rf_en_w, 1);
        check("lat_w0",   bus.rf_w0,   64'h05);
        check("lat_wv",   bus.rf_wv,   64'h0000_0000_1234_5678);
        idle(2, 0);

        // Read-only filter boundaries (accepted and dropped neighbours).
        drops = '{8'h90, 8'hFF, 8'h7C, 8'h7D, 8'h7F, 8'h80, 8'hE8, 8'hEF,
                  8'hF0, 8'hF8, 8'h7E, 8'hE9, 8'hF9, 8'hFE, 8'hFF, 8'h7C};
        d64   = '{0, 1, 1, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0};
        for (int i = 0; i < 16; i++) begin
            send(drops[i], {$urandom, $urandom}, d64[i], 0);
            idle(1, 0);
        end
        idle(3, 0);

        // Backpressure: four writes held, fifth waits for a slot.
        for (int i = 0; i < 4; i++) send(8'h20 + i, {$urandom, $urandom}, i[0], 1);
        check("bp_in_ready", bus.in_ready, 0);
        check("bp_count",    bus.count,    4);
        send(8'h30, {$urandom, $urandom}, 0, 0);
        idle(8, 0);

        // Hazard: 64-bit write to 0x10 covers 0x10 and 0x11 only.
        drv_qa = 8'h11;  drv_qb = 8'h10;
        send(8'h10, {$urandom, $urandom}, 1, 1);
        check("hz_q0_hi", bus.q0_busy, 1);
        check("hz_q1_lo", bus.q1_busy, 1);
        drv_qa = 8'h12;
        idle(1, 1);
        check("hz_q0_miss", bus.q0_busy, 0);
        drv_qa = 8'h11;
        idle(4, 0);
        check("hz_cleared", bus.q0_busy, 0);

        // Randomized traffic with random RF ownership and hazard queries.
        for (int i = 0; i < 600; i++) begin
            int a;
            a = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 255);
            drv_qa = $urandom_range(0, 33);
            drv_qb = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 33);
            step($urandom_range(0, 9) < 7, a, {$urandom, $urandom}, $urandom_range(0, 1),
                 $urandom_range(0, 9) < 3, f);
        end
        idle(8, 0);

        // Asynchronous reset while draining: three queued plus one on the RF port.
        for (int i = 0; i < 4; i++) send(8'h40 + i, {$urandom, $urandom}, 0, 1);
        idle(1, 0);
        check("mid_en_w",  bus.rf_en_w, 1);
        check("mid_count", bus.count,   3);
        #2;
        mon_en = 0;
        reset_n = 0;
        #1;
        check("arst_en_w",  bus.rf_en_w,  0);
        check("arst_count", bus.count,    0);
        check("arst_ready", bus.in_ready, 1);
        bus.rf_hold = 0;
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1;
        model_clear();
        mon_en = 1;
        idle(6, 0);
        check("post_rst_idle", bus.rf_en_w, 0);

`ifdef SGPR_WB_DROP_CNT_EN
        for (int i = 0; i < 3; i++) send(8'h90, '0, 0, 0);
        idle(1, 0);
        check("drop_cnt_3", bus.drop_cnt, 3);
        for (int i = 0; i < 65536; i++) step(1, 8'hF0, '0, 0, 0, f);
        idle(1, 0);
        check("drop_cnt_sat", bus.drop_cnt, 16'hFFFF);
`endif

        idle(2, 0);
        mon_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/sgpr_writeback_queue.md
Name: sgpr_writeback_queue

Overview:
- Write-side initiator for the scalar register file.
- Accepts SALU results over a valid/ready handshake and buffers them in a small FIFO.
- Drives the register file write port (w0/wv/en_w/en_64), one write per cycle.
- Filters writes to read-only SGPR addresses.
- Exposes a combinational busy lookup so operand fetch can stall on pending writes (RAW hazard).

Parameters:
- DEPTH, 4, FIFO entries (power of two, ≥2).
- ADDR_W, 8, SGPR address width.
- DATA_W, 64, write data width (low 32 bits used for 32-bit writes).

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  result valid.
- in_ready  out  1  queue can accept.
- in_addr  in  ADDR_W  destination SGPR.
- in_data  in  DATA_W  result data.
- in_is64  in  1  64-bit write to pair {addr+1, addr}.
- rf_hold  in  1  another writer owns the RF port this cycle.
- rf_en_w  out  1  register file write enable.
- rf_en_64  out  1  register file 64-bit write.
- rf_w0  out  ADDR_W  register file write address.
- rf_wv  out  DATA_W  register file write data.
- q0_addr  in  ADDR_W  operand-fetch source 0 address.
- q1_addr  in  ADDR_W  operand-fetch source 1 address.
- q0_busy  out  1  pending write targets q0_addr.
- q1_busy  out  1  pending write targets q1_addr.
- drop_err  out  1  one-cycle pulse: write discarded.
- count  out  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (async, reset_n low):
  - FIFO emptied; count=0; in_ready=1.
  - rf_en_w=0, rf_en_64=0, rf_w0=0, rf_wv=0.
  - drop_err=0.
  - Reset mid-drain discards every queued and in-flight write; no partial write is issued.
- Acceptance:
  - Transfer occurs when in_valid && in_ready at a rising edge.
  - in_ready = (count != DEPTH); it does not depend on rf_hold.
- Read-only filter, applied at acceptance:
  - Dropped addresses: 0x7D, 0x80–0xE8, 0xF0–0xF8.
  - Also dropped: any in_is64 write with in_addr=0xFF (pair would wrap to 0x00).
  - Also dropped: any in_is64 write whose addr+1 falls in a read-only range.
  - A dropped transfer is still handshaken (consumed) but not enqueued; drop_err=1 in the following cycle only.
- Drain:
  - At each edge where count>0 and rf_hold=0: pop the head into the registered rf_* outputs and set rf_en_w=1.
  - Otherwise rf_en_w=0 for the next cycle, and rf_w0/rf_wv hold their last values.
  - rf_en_64 = popped is64; it is 0 whenever rf_en_w=0.
- Latency:
  - Accepted at edge N into an empty queue → popped at edge N+1.
  - rf_en_w is high in the cycle between edges N+1 and N+2; the RF commits at N+2.
  - Sustained throughput: 1 write/cycle.
- Simultaneous push and pop:
  - Both occur at the same edge; count is unchanged.
  - When full, a push is not allowed even if a pop happens at the same edge.
- Order: writes reach the RF in strict FIFO order.
- Hazard lookup (combinational, per query port): busy=1 if the address matches any of:
  - any valid FIFO entry's addr;
  - addr+1 of any valid 64-bit FIFO entry;
  - the output stage while rf_en_w=1, using rf_w0, or rf_w0+1 when rf_en_64=1.
- A write being accepted in the current cycle is not included in busy.
- Data width: 32-bit writes place in_data[31:0] on rf_wv[31:0]; rf_wv[63:32] is driven 0.

Optional Feature:
- SGPR_WB_DROP_CNT_EN defined:
  - Adds output drop_cnt [15:0].
  - Increments on each dropped write, saturating at 0xFFFF.
  - Reset to 0.
- Undefined: the port and counter are absent; drop_err is unchanged in either case.

Decomposition:
- Package sgpr_pkg holds:
  - SGPR_ADDR_W.
  - Read-only range constants (RO_M0=0x7D, RO_CONST_LO/HI=0x80/0xE8, RO_SPECIAL_LO/HI=0xF0/0xF8).
  - Function is_read_only(addr).
  - Entry typedef {addr, data, is64}.
- One sub-module: sgpr_wb_fifo, a synchronous FIFO with push/pop/full/empty/count and exposed entry valid/addr/is64 vectors for the hazard compare.

Test Plan:
- Single write: addr 0x05, data 0x1234_5678, is64=0 into an empty queue → rf_en_w high exactly 2 cycles after acceptance; rf_w0=0x05, rf_wv=0x0000_0000_1234_5678, rf_en_64=0.
- Read-only drop: addr 0x90 → in_ready stays 1, no rf_en_w, drop_err pulses 1 cycle; same result for is64 with addr 0xFF and for is64 with addr 0x7C.
- Backpressure: rf_hold=1 while pushing 5 writes with DEPTH=4 → in_ready=0 after the 4th; release rf_hold → 4 writes emitted in order on consecutive cycles, then the 5th.
- Hazard: queue 64-bit write to 0x10 → q0_addr=0x11 and q1_addr=0x10 both busy; q0_addr=0x12 not busy; busy clears the cycle after rf_en_w drops.
- Async reset: assert reset_n low with 3 entries queued and rf_en_w=1 → rf_en_w=0 and count=0 immediately; no further writes after release.
- With SGPR_WB_DROP_CNT_EN: 3 drops → drop_cnt=3; force 0xFFFF+1 drops → saturates at 0xFFFF.
